// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch sequencer
package fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ, RESP, VALID, HALT} fetch_state_e;
    localparam int unsigned PC_INC = 4;
    localparam logic [13:0] DEFAULT_RESET_PC = 14'h0000;
endpackage

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC owner and ROM fetch sequencer with valid/ready delivery, redirects and misalignment trap
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              misalign_err,
    output logic [31:0]       fetch_cnt
);
    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, r_instr_pc;
    logic [31:0]       r_instr, r_cnt;
    logic              r_misalign;
    logic              w_active, w_redir_ok, w_redir_bad, w_handshake, w_capture;

    assign w_active    = r_state != HALT;
    assign w_redir_ok  = w_active && redirect_valid && redirect_pc[1:0] == 2'b00;
    assign w_redir_bad = w_active && redirect_valid && redirect_pc[1:0] != 2'b00;
    assign w_handshake = r_state == VALID && instr_ready && !w_redir_bad;
    // any redirect during RESP makes the returning word stale
    assign w_capture   = r_state == RESP && !redirect_valid;

    always_comb begin
        w_state_nxt = r_state;
        if (w_redir_bad)
            w_state_nxt = HALT;
        else if (w_redir_ok)
            w_state_nxt = fetch_en ? REQ : IDLE;
        else
            case (r_state)
                IDLE:    w_state_nxt = fetch_en ? REQ : IDLE;
                REQ:     w_state_nxt = RESP;
                RESP:    w_state_nxt = VALID;
                VALID:   w_state_nxt = instr_ready ? (fetch_en ? REQ : IDLE) : VALID;
                HALT:    w_state_nxt = HALT;
                default: w_state_nxt = IDLE;
            endcase
        w_pc_nxt = w_redir_ok ? redirect_pc : w_handshake ? r_pc + ADDR_W'(PC_INC) : r_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_cnt      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_instr    <= rom_data;
                r_instr_pc <= r_pc;
            end
            if (w_handshake)
                r_cnt <= r_cnt + 32'd1;
            if (w_redir_bad)
                r_misalign <= 1'b1;
        end
    end

    assign rom_addr     = r_pc;
    assign instr_valid  = r_state == VALID;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign misalign_err = r_misalign;
    assign fetch_cnt    = r_cnt;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scoreboard bench with a program-order fetch model and a registered ROM model
module tb_instr_fetch_ctrl;
    typedef struct {int pc; logic [31:0] word;} exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, fetch_en = 1'b0, instr_ready = 1'b0, redirect_valid = 1'b0;
    logic [13:0] redirect_pc = '0, rom_addr, instr_pc;
    logic [31:0] rom_data, instr, fetch_cnt;
    logic        instr_valid, misalign_err;
    logic [31:0] mem [0:4095];

    int          m_pc, n_cmp, n_bad;
    logic [31:0] m_cnt;
    logic        m_halt, m_mis, mon_en = 1'b0, prev_v = 1'b0;
    exp_t        q[$];

    instr_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_err(misalign_err),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= mem[rom_addr[13:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int pc);
        q.push_back('{pc, mem[pc / 4]});
    endfunction

    // Program-order model: the next instruction presented is always the one at m_pc
    task automatic step(input logic fe, input logic rdy, input logic rv, input int rpc);
        logic v;
        fetch_en = fe; instr_ready = rdy; redirect_valid = rv; redirect_pc = 14'(rpc);
        v = instr_valid;
        @(posedge clk); #1;
        if (!m_halt) begin
            if (rv && rpc % 4 != 0) begin
                m_halt = 1'b1;
                m_mis = 1'b1;
            end else begin
                if (v && rdy) begin
                    m_cnt = m_cnt + 1;
                    m_pc = (m_pc + 4) % 16384;
                end
                if (rv) begin
                    m_pc = rpc;
                    q.delete();
                end
                if ((v && rdy) || rv) push_exp(m_pc);
            end
        end
    endtask

    task automatic rst_step();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_pc = 0; m_cnt = 0; m_halt = 1'b0; m_mis = 1'b0;
        q.delete();
        push_exp(0);
    endtask

    task automatic wait_valid(input logic fe, input logic rdy, input int max, output int n);
        n = 0;
        do begin
            step(fe, rdy, 1'b0, 0);
            n++;
        end while (!instr_valid && n < max);
        chk("wait_valid", instr_valid, 1);
    endtask

    always @(negedge clk) if (mon_en) begin
        exp_t e;
        chk("rom_addr", rom_addr, m_pc);
        chk("fetch_cnt", fetch_cnt, m_cnt);
        chk("misalign_err", misalign_err, m_mis);
        if (m_halt) chk("halt_valid", instr_valid, 0);
        if (instr_valid && !prev_v) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
            end else begin
                e = q.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.word);
            end
        end
        prev_v = instr_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic fe, rdy, rv;
        int rpc;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'h800000b7;
        mem[1] = 32'h00000113;
        mem['h5b0 / 4] = 32'hc0001073;
        rst_step();
        rst_step();
        mon_en = 1'b1;
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_valid", instr_valid, 0);

        wait_valid(1, 1, 20, n);
        chk("first_latency", n, 3);
        chk("first_instr", instr, 32'h800000b7);
        chk("first_pc", instr_pc, 0);
        wait_valid(1, 1, 20, n);
        chk("second_latency", n, 3);
        chk("second_instr", instr, 32'h00000113);
        chk("second_pc", instr_pc, 4);
        step(0, 1, 0, 0);
        chk("cnt_after_two", fetch_cnt, 2);

        wait_valid(1, 0, 20, n);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            chk("bp_instr", instr, mem[2]);
            chk("bp_pc", instr_pc, 8);
            chk("bp_addr", rom_addr, 8);
            chk("bp_cnt", fetch_cnt, 2);
            chk("bp_valid", instr_valid, 1);
        end
        step(0, 1, 0, 0);
        chk("bp_release_cnt", fetch_cnt, 3);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 'h5b0);
        chk("redir_addr", rom_addr, 'h5b0);
        chk("redir_valid", instr_valid, 0);
        wait_valid(1, 0, 20, n);
        chk("redir_latency", n, 2);
        chk("redir_pc", instr_pc, 'h5b0);
        chk("redir_instr", instr, 32'hc0001073);

        step(1, 1, 1, 'h100);
        chk("hs_redir_cnt", fetch_cnt, 4);
        chk("hs_redir_addr", rom_addr, 'h100);
        wait_valid(1, 0, 20, n);
        chk("hs_redir_pc", instr_pc, 'h100);

        step(1, 0, 1, 'h3ffc);
        wait_valid(1, 0, 20, n);
        chk("wrap_pc", instr_pc, 'h3ffc);
        step(0, 1, 0, 0);
        chk("wrap_addr", rom_addr, 0);
        chk("wrap_cnt", fetch_cnt, 5);

        wait_valid(1, 0, 20, n);
        step(1, 0, 1, 'h40);
        wait_valid(1, 0, 20, n);
        step(1, 1, 0, 0);
        chk("pre_rst_addr", rom_addr, 'h44);
        rst_step();
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_pc", instr_pc, 0);
        chk("mid_rst_cnt", fetch_cnt, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_addr", rom_addr, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("idle_valid", instr_valid, 0);
        end

        step(1, 1, 0, 0);
        step(1, 1, 1, 'h102);
        chk("mis_flag", misalign_err, 1);
        chk("mis_addr", rom_addr, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1'($urandom_range(0, 1)), int'({$urandom_range(0, 4095), 2'b00}));
            chk("halt_stays", instr_valid, 0);
        end
        rst_step();
        chk("mis_cleared", misalign_err, 0);

        for (int c = 0; c < 6; c++) begin
            rst_step();
            for (int i = 0; i < 500; i++) begin
                fe  = $urandom_range(0, 3) != 0;
                rdy = 1'($urandom_range(0, 1));
                rv  = $urandom_range(0, 19) == 0;
                rpc = $urandom_range(0, 49) == 0 ? int'({$urandom_range(0, 4095), 2'($urandom_range(1, 3))})
                                                  : int'({$urandom_range(0, 4095), 2'b00});
                step(fe, rdy, rv, rpc);
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
